// File: rtl/lsu_buffered_if.sv
// lsu_buffered_if: execute op, data-memory bus, writeback and exception signals of the load/store unit
interface lsu_buffered_if #(parameter int XLEN = 32);
  logic            in_valid;
  logic            in_ready;
  logic            in_is_store;
  logic [1:0]      in_size;
  logic            in_unsigned;
  logic [XLEN-1:0] in_addr;
  logic [XLEN-1:0] in_wdata;
  logic [4:0]      in_rd_addr;
  logic            mem_req_valid;
  logic            mem_req_ready;
  logic            mem_req_we;
  logic [XLEN-1:0] mem_req_addr;
  logic [XLEN-1:0] mem_req_wdata;
  logic [3:0]      mem_req_be;
  logic            mem_rsp_valid;
  logic [XLEN-1:0] mem_rsp_rdata;
  logic            wb_valid;
  logic [4:0]      wb_rd_addr;
  logic [XLEN-1:0] wb_data;
  logic            exc_valid;
  logic [XLEN-1:0] exc_addr;
  logic            sb_empty;
  modport master (
    input  in_valid, in_is_store, in_size, in_unsigned, in_addr, in_wdata, in_rd_addr,
           mem_req_ready, mem_rsp_valid, mem_rsp_rdata,
    output in_ready, mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, mem_req_be,
           wb_valid, wb_rd_addr, wb_data, exc_valid, exc_addr, sb_empty
  );
  modport slave (
    output in_valid, in_is_store, in_size, in_unsigned, in_addr, in_wdata, in_rd_addr,
           mem_req_ready, mem_rsp_valid, mem_rsp_rdata,
    input  in_ready, mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, mem_req_be,
           wb_valid, wb_rd_addr, wb_data, exc_valid, exc_addr, sb_empty
  );
endinterface

// File: rtl/lsu_buffered.sv
// lsu_buffered: load/store unit with posted store buffer, byte lanes, misalignment traps and registered writeback
module lsu_buffered #(
  parameter int XLEN     = 32,
  parameter int SB_DEPTH = 4
) (
  input logic            clk,
  input logic            rst,
  lsu_buffered_if.master bus
);
  localparam int PW = $clog2(SB_DEPTH);
  localparam int EW = 2 * XLEN + 4;
  typedef enum logic [1:0] {IDLE, WAIT_SB, LD_REQ, LD_RSP} state_e;
  state_e                      state_q, state_d;
  logic [SB_DEPTH-1:0][EW-1:0] sb_q, sb_d;
  logic [PW-1:0]               head_q, head_d, tail_q, tail_d;
  logic [PW:0]                 cnt_q, cnt_d;
  logic [XLEN-1:0]             ld_addr_q, ld_addr_d;
  logic [1:0]                  ld_size_q, ld_size_d;
  logic                        ld_uns_q, ld_uns_d;
  logic [4:0]                  ld_rd_q, ld_rd_d;
  logic                        wb_valid_q, wb_valid_d;
  logic [4:0]                  wb_rd_q, wb_rd_d;
  logic [XLEN-1:0]             wb_data_q, wb_data_d;
  logic                        exc_valid_q, exc_valid_d;
  logic [XLEN-1:0]             exc_addr_q, exc_addr_d;
  logic                        sb_full, mis, accept, push, pop, ld_acc, sb_issue, ld_issue, rsp;
  logic [XLEN-1:0]             lane_wdata, shifted, ld_ext;
  logic [3:0]                  lane_be;
  logic [EW-1:0]               head_e;
  always_comb begin
    sb_full = cnt_q == (PW+1)'(SB_DEPTH);
    mis = bus.in_size == 2'd1 ? bus.in_addr[0] : bus.in_size[1] & (bus.in_addr[1:0] != 2'd0);
    bus.in_ready = (state_q == IDLE) & (!bus.in_is_store | !sb_full | mis);
    accept = bus.in_valid & bus.in_ready;
    push = accept & bus.in_is_store & !mis;
    ld_acc = accept & !bus.in_is_store & !mis;
    lane_wdata = bus.in_size == 2'd0 ? {4{bus.in_wdata[7:0]}} :
                 bus.in_size == 2'd1 ? {2{bus.in_wdata[15:0]}} : bus.in_wdata;
    lane_be = bus.in_size == 2'd0 ? 4'b0001 << bus.in_addr[1:0] :
              bus.in_size == 2'd1 ? 4'b0011 << bus.in_addr[1:0] : 4'b1111;
    sb_issue = ((state_q == IDLE) | (state_q == WAIT_SB)) & (cnt_q != '0);
    ld_issue = state_q == LD_REQ;
    pop = sb_issue & bus.mem_req_ready;
    cnt_d = cnt_q + (PW+1)'(push) - (PW+1)'(pop);
    head_d = head_q + PW'(pop);
    tail_d = tail_q + PW'(push);
    sb_d = sb_q;
    if (push) sb_d[tail_q] = {bus.in_addr[XLEN-1:2], 2'b00, lane_wdata, lane_be};
    head_e = sb_q[head_q];
    bus.mem_req_valid = sb_issue | ld_issue;
    bus.mem_req_we = sb_issue;
    bus.mem_req_addr = ld_issue ? {ld_addr_q[XLEN-1:2], 2'b00} : sb_issue ? head_e[EW-1 -: XLEN] : '0;
    bus.mem_req_wdata = sb_issue ? head_e[XLEN+3:4] : '0;
    bus.mem_req_be = ld_issue ? 4'b1111 : sb_issue ? head_e[3:0] : 4'b0000;
    rsp = (state_q == LD_RSP) & bus.mem_rsp_valid;
    shifted = bus.mem_rsp_rdata >> {ld_addr_q[1:0], 3'b000};
    ld_ext = ld_size_q == 2'd0 ? {{(XLEN-8){~ld_uns_q & shifted[7]}}, shifted[7:0]} :
             ld_size_q == 2'd1 ? {{(XLEN-16){~ld_uns_q & shifted[15]}}, shifted[15:0]} : shifted;
    ld_addr_d = ld_acc ? bus.in_addr : ld_addr_q;
    ld_size_d = ld_acc ? bus.in_size : ld_size_q;
    ld_uns_d = ld_acc ? bus.in_unsigned : ld_uns_q;
    ld_rd_d = ld_acc ? bus.in_rd_addr : ld_rd_q;
    wb_valid_d = rsp;
    wb_rd_d = rsp ? ld_rd_q : wb_rd_q;
    wb_data_d = rsp ? ld_ext : wb_data_q;
    exc_valid_d = accept & mis;
    exc_addr_d = exc_valid_d ? bus.in_addr : exc_addr_q;
    state_d = state_q == IDLE    ? (ld_acc ? (cnt_d == '0 ? LD_REQ : WAIT_SB) : IDLE) :
              state_q == WAIT_SB ? (cnt_d == '0 ? LD_REQ : WAIT_SB) :
              state_q == LD_REQ  ? (bus.mem_req_ready ? LD_RSP : LD_REQ) :
                                   (bus.mem_rsp_valid ? IDLE : LD_RSP);
    bus.wb_valid = wb_valid_q;
    bus.wb_rd_addr = wb_rd_q;
    bus.wb_data = wb_data_q;
    bus.exc_valid = exc_valid_q;
    bus.exc_addr = exc_addr_q;
    bus.sb_empty = cnt_q == '0;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sb_q <= '0;
      head_q <= '0;
      tail_q <= '0;
      cnt_q <= '0;
      ld_addr_q <= '0;
      ld_size_q <= '0;
      ld_uns_q <= 1'b0;
      ld_rd_q <= '0;
      wb_valid_q <= 1'b0;
      wb_rd_q <= '0;
      wb_data_q <= '0;
      exc_valid_q <= 1'b0;
      exc_addr_q <= '0;
    end else begin
      state_q <= state_d;
      sb_q <= sb_d;
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q <= cnt_d;
      ld_addr_q <= ld_addr_d;
      ld_size_q <= ld_size_d;
      ld_uns_q <= ld_uns_d;
      ld_rd_q <= ld_rd_d;
      wb_valid_q <= wb_valid_d;
      wb_rd_q <= wb_rd_d;
      wb_data_q <= wb_data_d;
      exc_valid_q <= exc_valid_d;
      exc_addr_q <= exc_addr_d;
    end
  end
endmodule

// File: tb/tb_lsu_buffered.sv
// tb_lsu_buffered: scoreboard bench for the buffered load/store unit
module tb_lsu_buffered;
  typedef struct {logic we; logic [31:0] addr; logic [31:0] wdata; logic [3:0] be;} req_t;
  typedef struct {logic [4:0] rd; logic [31:0] data; int at;} wb_t;
  logic clk, rst;
  int cyc, n_chk, n_fail, wb_seen, saved;
  req_t req_q[$];
  wb_t wb_q[$];
  logic [31:0] exc_q[$];
  logic rsp_go, rsp_force, rsp_off, held_v;
  logic [31:0] rd_word;
  logic [71:0] held;
  lsu_buffered_if #(.XLEN(32)) bus ();
  lsu_buffered #(.XLEN(32), .SB_DEPTH(4)) dut (.clk(clk), .rst(rst), .bus(bus));
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] ld_exp(input logic [31:0] w, input logic [31:0] a, input logic [1:0] sz, input logic un);
    int i;
    logic [7:0] b0, b1;
    i = int'(a[1:0]);
    b0 = w[8*i +: 8];
    b1 = w[(8*i+8)%32 +: 8];
    return sz == 2'd0 ? (un ? {24'h0, b0} : {{24{b0[7]}}, b0}) :
           sz == 2'd1 ? (un ? {16'h0, b1, b0} : {{16{b1[7]}}, b1, b0}) : w;
  endfunction
  task automatic op(input logic st, input logic [1:0] sz, input logic un, input logic [31:0] a, input logic [31:0] d, input logic [4:0] rd);
    bit done;
    req_t r;
    wb_t w;
    done = 0;
    bus.in_valid = 1; bus.in_is_store = st; bus.in_size = sz; bus.in_unsigned = un;
    bus.in_addr = a; bus.in_wdata = d; bus.in_rd_addr = rd;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        done = 1;
        if ((sz == 2'd1 && a[0]) || (sz[1] && a[1:0] != 2'd0)) exc_q.push_back(a);
        else if (st) begin
          r.we = 1; r.addr = {a[31:2], 2'b00};
          r.wdata = sz == 2'd0 ? {4{d[7:0]}} : sz == 2'd1 ? {2{d[15:0]}} : d;
          r.be = sz == 2'd0 ? 4'b0001 << a[1:0] : sz == 2'd1 ? 4'b0011 << a[1:0] : 4'b1111;
          req_q.push_back(r);
        end else begin
          r.we = 0; r.addr = {a[31:2], 2'b00}; r.wdata = 0; r.be = 4'b1111;
          req_q.push_back(r);
          w.rd = rd; w.data = ld_exp(rd_word, a, sz, un);
          w.at = (bus.sb_empty && bus.mem_req_ready) ? cyc + 3 : -1;
          wb_q.push_back(w);
        end
      end
      @(posedge clk); #1;
    end
    check("op_accept", done, 1);
    bus.in_valid = 0;
  endtask
  task automatic drain();
    int n;
    n = 0;
    while ((req_q.size() + wb_q.size() + exc_q.size()) != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    check("drain_left", req_q.size() + wb_q.size() + exc_q.size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask
  task automatic reset_checks(input string tag);
    check({tag, "_ready_empty"}, {bus.in_ready, bus.sb_empty}, 2'b11);
    check({tag, "_req"}, {bus.mem_req_valid, bus.mem_req_we, bus.mem_req_addr, bus.mem_req_wdata, bus.mem_req_be}, 0);
    check({tag, "_wb"}, {bus.wb_valid, bus.wb_rd_addr, bus.wb_data}, 0);
    check({tag, "_exc"}, {bus.exc_valid, bus.exc_addr}, 0);
  endtask
  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1;
    req_q.delete(); wb_q.delete(); exc_q.delete();
    #1;
  endtask
  initial begin
    req_t e;
    wb_t w;
    bus.mem_rsp_valid = 0; bus.mem_rsp_rdata = 0; rsp_go = 0; held_v = 0; held = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        rsp_go = 0;
        held_v = 0;
      end else begin
        if (held_v) check("req_stable", {bus.mem_req_valid, bus.mem_req_we, bus.mem_req_addr, bus.mem_req_wdata, bus.mem_req_be}, held[69:0]);
        held_v = bus.mem_req_valid & !bus.mem_req_ready;
        held = {2'b00, bus.mem_req_valid, bus.mem_req_we, bus.mem_req_addr, bus.mem_req_wdata, bus.mem_req_be};
        if (bus.mem_req_valid && bus.mem_req_ready) begin
          if (req_q.size() == 0) check("req_unexpected", 1, 0);
          else begin
            e = req_q.pop_front();
            check("req_we", bus.mem_req_we, e.we);
            check("req_addr", bus.mem_req_addr, e.addr);
            check("req_be", bus.mem_req_be, e.be);
            if (e.we) check("req_wdata", bus.mem_req_wdata, e.wdata);
            else if (!rsp_off) rsp_go = 1;
          end
        end
        if (bus.wb_valid) begin
          wb_seen++;
          if (wb_q.size() == 0) check("wb_unexpected", 1, 0);
          else begin
            w = wb_q.pop_front();
            check("wb_rd", bus.wb_rd_addr, w.rd);
            check("wb_data", bus.wb_data, w.data);
            if (w.at >= 0) check("wb_latency", cyc, w.at);
          end
        end
        if (bus.exc_valid) begin
          if (exc_q.size() == 0) check("exc_unexpected", 1, 0);
          else check("exc_addr", bus.exc_addr, exc_q.pop_front());
        end
      end
      @(posedge clk); #1;
      bus.mem_rsp_valid = (rsp_go & !rst) | rsp_force;
      bus.mem_rsp_rdata = rd_word;
      rsp_go = 0;
    end
  end
  initial begin
    rst = 1; rsp_force = 0; rsp_off = 0; rd_word = 0;
    bus.in_valid = 0; bus.in_is_store = 0; bus.in_size = 0; bus.in_unsigned = 0;
    bus.in_addr = 0; bus.in_wdata = 0; bus.in_rd_addr = 0; bus.mem_req_ready = 1;
    @(posedge clk); #1;
    reset_checks("rst0");
    @(posedge clk); #1;
    rst = 0;
    op(1, 2'd0, 0, 32'h103, 32'hAB, 0);
    drain();
    rd_word = 32'h8001_1234;
    op(0, 2'd1, 0, 32'h102, 0, 5'd3);
    drain();
    op(0, 2'd1, 1, 32'h102, 0, 5'd4);
    drain();
    op(0, 2'd0, 0, 32'h101, 0, 5'd5);
    op(0, 2'd0, 1, 32'h103, 0, 5'd6);
    op(0, 2'd0, 0, 32'h103, 0, 5'd7);
    op(0, 2'd2, 0, 32'h100, 0, 5'd8);
    op(1, 2'd1, 0, 32'h106, 32'h5555_BEEF, 0);
    drain();
    bus.mem_req_ready = 0;
    for (int i = 0; i < 4; i++) op(1, 2'd2, 0, 32'h300 + 32'(4 * i), 32'h1111_0000 + 32'(i), 0);
    bus.in_valid = 1; bus.in_is_store = 1; bus.in_size = 2'd2; bus.in_addr = 32'h310;
    @(negedge clk);
    check("sb_full_ready", bus.in_ready, 0);
    check("sb_full_empty", bus.sb_empty, 0);
    @(posedge clk); #1;
    bus.in_valid = 0;
    bus.mem_req_ready = 1;
    drain();
    check("sb_drained", bus.sb_empty, 1);
    bus.mem_req_ready = 0;
    rd_word = 32'hCAFE_F00D;
    op(1, 2'd2, 0, 32'h200, 32'hCAFE_F00D, 0);
    op(0, 2'd2, 0, 32'h200, 0, 5'd9);
    @(negedge clk);
    check("wait_sb_ready", bus.in_ready, 0);
    check("wait_sb_head_write", {bus.mem_req_valid, bus.mem_req_we}, 2'b11);
    repeat (3) @(posedge clk);
    #1;
    bus.mem_req_ready = 1;
    drain();
    op(0, 2'd2, 0, 32'h1002, 0, 5'd10);
    op(1, 2'd1, 0, 32'h1001, 32'h1234, 0);
    drain();
    bus.mem_req_ready = 0;
    op(1, 2'd2, 0, 32'h400, 32'hAAAA_0001, 0);
    op(1, 2'd2, 0, 32'h404, 32'hAAAA_0002, 0);
    op(0, 2'd2, 0, 32'h400, 0, 5'd11);
    do_reset();
    reset_checks("rst_wait");
    @(posedge clk); #1;
    rst = 0;
    bus.mem_req_ready = 1;
    rsp_off = 1;
    op(0, 2'd2, 0, 32'h404, 0, 5'd12);
    for (int i = 0; i < 20 && req_q.size() != 0; i++) @(posedge clk);
    check("ldrsp_req_seen", req_q.size(), 0);
    do_reset();
    reset_checks("rst_ldrsp");
    @(posedge clk); #1;
    rst = 0;
    saved = wb_seen;
    @(negedge clk);
    rsp_force = 1;
    @(negedge clk);
    rsp_force = 0;
    rsp_off = 0;
    repeat (4) @(posedge clk);
    #1;
    check("late_rsp_no_wb", wb_seen, saved);
    check("late_rsp_idle", {bus.in_ready, bus.sb_empty, bus.mem_req_valid}, 3'b110);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL global_timeout got=%0d exp=finish", cyc);
    $fatal(1, "timeout");
  end
endmodule
